// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the request/ack instruction port,
// absorbs stalls in a one-entry skid buffer and applies EX-stage redirects.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_pc4_q, if_id_pc4_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;

  logic [31:0] redir_tgt;
  logic [31:0] pc_inc;
  logic        unused_redirect_lsbs;

  assign redir_tgt            = {redirect_pc[31:2], 2'b00};
  assign pc_inc               = pc_q + 32'd4;
  assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

  // Request is gated by rstn directly so it drops the instant reset asserts.
  assign imem_req  = rstn & (state_q != HOLD);
  assign imem_addr = pc_q;

  assign if_id_valid = if_id_valid_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_pc4   = if_id_pc4_q;
  assign if_id_instr = if_id_instr_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_d        = pend_q;
    skid_pc_d     = skid_pc_q;
    skid_instr_d  = skid_instr_q;
    if_id_valid_d = if_id_valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_instr_d = if_id_instr_q;

    if (redirect) begin
      if_id_valid_d = 1'b0;
      if_id_instr_d = NOP_INSTR;
      skid_pc_d     = '0;
      skid_instr_d  = NOP_INSTR;
      unique case (state_q)
        HOLD: begin
          pc_d    = redir_tgt;
          state_d = FETCH;
        end
        default: begin
          // An outstanding request must complete before the PC may move.
          if (imem_ack) begin
            pc_d    = redir_tgt;
            state_d = FETCH;
          end else begin
            pend_d  = redir_tgt;
            state_d = DRAIN;
          end
        end
      endcase
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem_ack) begin
            pc_d = pc_inc;
            if (stall) begin
              skid_pc_d    = pc_q;
              skid_instr_d = imem_rdata;
              state_d      = HOLD;
            end else begin
              if_id_valid_d = 1'b1;
              if_id_pc_d    = pc_q;
              if_id_pc4_d   = pc_inc;
              if_id_instr_d = imem_rdata;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            if_id_valid_d = 1'b1;
            if_id_pc_d    = skid_pc_q;
            if_id_pc4_d   = skid_pc_q + 32'd4;
            if_id_instr_d = skid_instr_q;
            state_d       = FETCH;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            pc_d    = pend_q;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      pend_q        <= '0;
      skid_pc_q     <= '0;
      skid_instr_q  <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= '0;
      if_id_pc4_q   <= '0;
      if_id_instr_q <= NOP_INSTR;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_q        <= pend_d;
      skid_pc_q     <= skid_pc_d;
      skid_instr_q  <= skid_instr_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_instr_q <= if_id_instr_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus a randomized run against a
// transaction-level fetch model with a variable-latency memory.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rstn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;

  int checks = 0;
  int errors = 0;

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .if_id_valid(if_id_valid),
    .if_id_pc   (if_id_pc),
    .if_id_pc4  (if_id_pc4),
    .if_id_instr(if_id_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h5A00_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    tick();
    tick();
    rstn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    tick();
    tick();
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL reset_req: got %b, expected 0", imem_req);
    end
    checks++;
    if ({if_id_valid, if_id_pc, if_id_pc4, if_id_instr} !== {1'b0, 32'h0, 32'h0, NOP}) begin
      errors++; $display("FAIL reset_ifid: got %h, expected %h",
        {if_id_valid, if_id_pc, if_id_pc4, if_id_instr}, {1'b0, 32'h0, 32'h0, NOP});
    end
    imem_ack = 1'b0;
    rstn = 1'b1;
    #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL reset_first_req: got %h, expected %h", {imem_req, imem_addr}, {1'b1, 32'h0});
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] a;
    do_reset();
    checks++;
    if (if_id_valid !== 1'b0) begin
      errors++; $display("FAIL zw_valid_first: got %b, expected 0", if_id_valid);
    end
    imem_ack = 1'b1;
    for (int k = 0; k < 6; k++) begin
      a = 32'(4 * k);
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, a}) begin
        errors++; $display("FAIL zw_addr: got %h, expected %h", {imem_req, imem_addr}, {1'b1, a});
      end
      imem_rdata = instr_of(a);
      tick();
      checks++;
      if ({if_id_valid, if_id_pc, if_id_pc4, if_id_instr} !== {1'b1, a, a + 32'd4, instr_of(a)}) begin
        errors++; $display("FAIL zw_ifid: got %h, expected %h",
          {if_id_valid, if_id_pc, if_id_pc4, if_id_instr}, {1'b1, a, a + 32'd4, instr_of(a)});
      end
    end
  endtask

  task automatic test_latency3();
    logic [31:0] a;
    logic [127:0] exp_prev, exp_new;
    do_reset();
    exp_prev = {31'h0, 1'b0, 32'h0, 32'h0, NOP};
    for (int k = 0; k < 3; k++) begin
      a = 32'(4 * k);
      exp_new = {31'h0, 1'b1, a, a + 32'd4, instr_of(a)};
      for (int c = 0; c < 3; c++) begin
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, a}) begin
          errors++; $display("FAIL lat_addr: got %h, expected %h", {imem_req, imem_addr}, {1'b1, a});
        end
        imem_ack = (c == 2);
        imem_rdata = (c == 2) ? instr_of(a) : 32'hBAD0_0000;
        tick();
        checks++;
        if ({31'h0, if_id_valid, if_id_pc, if_id_pc4, if_id_instr} !== ((c == 2) ? exp_new : exp_prev)) begin
          errors++; $display("FAIL lat_ifid: got %h, expected %h",
            {31'h0, if_id_valid, if_id_pc, if_id_pc4, if_id_instr}, (c == 2) ? exp_new : exp_prev);
        end
      end
      exp_prev = exp_new;
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_stall_skid();
    do_reset();
    imem_ack = 1'b1;
    imem_rdata = instr_of(32'h0); tick();
    imem_rdata = instr_of(32'h4); tick();
    stall = 1'b1;
    imem_rdata = instr_of(32'h8);
    tick();
    imem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({imem_req, if_id_valid, if_id_pc, if_id_pc4, if_id_instr} !==
          {1'b0, 1'b1, 32'h4, 32'h8, instr_of(32'h4)}) begin
        errors++; $display("FAIL stall_hold: got %h, expected %h",
          {imem_req, if_id_valid, if_id_pc, if_id_pc4, if_id_instr},
          {1'b0, 1'b1, 32'h4, 32'h8, instr_of(32'h4)});
      end
      if (i < 3) tick();
    end
    stall = 1'b0;
    tick();
    checks++;
    if ({imem_req, imem_addr, if_id_valid, if_id_pc, if_id_pc4, if_id_instr} !==
        {1'b1, 32'hC, 1'b1, 32'h8, 32'hC, instr_of(32'h8)}) begin
      errors++; $display("FAIL stall_release: got %h, expected %h",
        {imem_req, imem_addr, if_id_valid, if_id_pc, if_id_pc4, if_id_instr},
        {1'b1, 32'hC, 1'b1, 32'h8, 32'hC, instr_of(32'h8)});
    end
    imem_ack = 1'b1;
    imem_rdata = instr_of(32'hC);
    tick();
    checks++;
    if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, 32'hC, instr_of(32'hC)}) begin
      errors++; $display("FAIL stall_next: got %h, expected %h",
        {if_id_valid, if_id_pc, if_id_instr}, {1'b1, 32'hC, instr_of(32'hC)});
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_redirect_drain();
    do_reset();
    imem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      imem_rdata = instr_of(32'(4 * k));
      tick();
    end
    imem_ack = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    redirect_pc = '0;
    checks++;
    if ({imem_req, imem_addr, if_id_valid, if_id_instr} !== {1'b1, 32'h10, 1'b0, NOP}) begin
      errors++; $display("FAIL drain_hold: got %h, expected %h",
        {imem_req, imem_addr, if_id_valid, if_id_instr}, {1'b1, 32'h10, 1'b0, NOP});
    end
    imem_ack = 1'b1;
    imem_rdata = instr_of(32'h10);
    tick();
    checks++;
    if ({imem_req, imem_addr, if_id_valid, if_id_instr} !== {1'b1, 32'h100, 1'b0, NOP}) begin
      errors++; $display("FAIL drain_target: got %h, expected %h",
        {imem_req, imem_addr, if_id_valid, if_id_instr}, {1'b1, 32'h100, 1'b0, NOP});
    end
    imem_rdata = instr_of(32'h100);
    tick();
    checks++;
    if ({if_id_valid, if_id_pc, if_id_pc4, if_id_instr} !== {1'b1, 32'h100, 32'h104, instr_of(32'h100)}) begin
      errors++; $display("FAIL drain_first: got %h, expected %h",
        {if_id_valid, if_id_pc, if_id_pc4, if_id_instr}, {1'b1, 32'h100, 32'h104, instr_of(32'h100)});
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_redirect_stall_ack();
    do_reset();
    imem_ack = 1'b1;
    imem_rdata = instr_of(32'h0);
    tick();
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0040;
    imem_rdata = instr_of(32'h4);
    tick();
    stall = 1'b0;
    redirect = 1'b0;
    checks++;
    if ({imem_req, imem_addr, if_id_valid, if_id_instr} !== {1'b1, 32'h40, 1'b0, NOP}) begin
      errors++; $display("FAIL flush_wins: got %h, expected %h",
        {imem_req, imem_addr, if_id_valid, if_id_instr}, {1'b1, 32'h40, 1'b0, NOP});
    end
    imem_rdata = instr_of(32'h40);
    tick();
    checks++;
    if ({if_id_valid, if_id_pc, if_id_pc4, if_id_instr} !== {1'b1, 32'h40, 32'h44, instr_of(32'h40)}) begin
      errors++; $display("FAIL flush_next: got %h, expected %h",
        {if_id_valid, if_id_pc, if_id_pc4, if_id_instr}, {1'b1, 32'h40, 32'h44, instr_of(32'h40)});
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_wrap_async_reset();
    do_reset();
    imem_ack = 1'b1;
    imem_rdata = instr_of(32'h0);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_addr: got %h, expected %h", imem_addr, 32'hFFFF_FFFC);
    end
    imem_rdata = instr_of(32'hFFFF_FFFC);
    tick();
    checks++;
    if ({imem_addr, if_id_valid, if_id_pc, if_id_pc4, if_id_instr} !==
        {32'h0, 1'b1, 32'hFFFF_FFFC, 32'h0, instr_of(32'hFFFF_FFFC)}) begin
      errors++; $display("FAIL wrap_ifid: got %h, expected %h",
        {imem_addr, if_id_valid, if_id_pc, if_id_pc4, if_id_instr},
        {32'h0, 1'b1, 32'hFFFF_FFFC, 32'h0, instr_of(32'hFFFF_FFFC)});
    end
    imem_rdata = instr_of(32'h0);
    tick();
    checks++;
    if ({if_id_valid, if_id_pc, if_id_pc4} !== {1'b1, 32'h0, 32'h4}) begin
      errors++; $display("FAIL wrap_after: got %h, expected %h",
        {if_id_valid, if_id_pc, if_id_pc4}, {1'b1, 32'h0, 32'h4});
    end
    imem_ack = 1'b0;
    tick();
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({imem_req, imem_addr, if_id_valid, if_id_pc, if_id_pc4, if_id_instr} !==
        {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, NOP}) begin
      errors++; $display("FAIL async_reset: got %h, expected %h",
        {imem_req, imem_addr, if_id_valid, if_id_pc, if_id_pc4, if_id_instr},
        {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, NOP});
    end
  endtask

  task automatic test_random();
    logic [31:0] m_pc, m_tgt, m_skid_pc, m_skid_ins;
    logic        m_drain, m_skid;
    logic        e_valid;
    logic [31:0] e_pc, e_pc4, e_instr;
    logic        busy, a, s, r;
    int unsigned cnt;
    logic [31:0] t, d;

    do_reset();
    m_pc = 32'h0; m_tgt = '0; m_skid_pc = '0; m_skid_ins = '0;
    m_drain = 1'b0; m_skid = 1'b0;
    e_valid = 1'b0; e_pc = '0; e_pc4 = '0; e_instr = NOP;
    busy = 1'b0; cnt = 0;

    for (int n = 0; n < 600; n++) begin
      checks++;
      if (imem_req !== !m_skid) begin
        errors++; $display("FAIL rnd_req: cycle %0d got %b, expected %b", n, imem_req, !m_skid);
      end
      if (!m_skid) begin
        checks++;
        if (imem_addr !== m_pc) begin
          errors++; $display("FAIL rnd_addr: cycle %0d got %h, expected %h", n, imem_addr, m_pc);
        end
      end
      checks++;
      if ({if_id_valid, if_id_pc, if_id_pc4, if_id_instr} !== {e_valid, e_pc, e_pc4, e_instr}) begin
        errors++; $display("FAIL rnd_ifid: cycle %0d got %h, expected %h", n,
          {if_id_valid, if_id_pc, if_id_pc4, if_id_instr}, {e_valid, e_pc, e_pc4, e_instr});
      end

      a = 1'b0;
      if (imem_req) begin
        if (!busy) begin
          busy = 1'b1;
          cnt = $urandom_range(0, 3);
        end
        if (cnt == 0) begin
          a = 1'b1;
          busy = 1'b0;
        end else begin
          cnt--;
        end
      end
      s = ($urandom_range(0, 99) < 30);
      r = ($urandom_range(0, 99) < 7);
      t = $urandom;
      d = instr_of(imem_addr);
      imem_ack = a; imem_rdata = d; stall = s; redirect = r; redirect_pc = t;

      if (r) begin
        e_valid = 1'b0;
        e_instr = NOP;
        if (m_skid) begin
          m_skid = 1'b0;
          m_pc = {t[31:2], 2'b00};
        end else if (a) begin
          m_drain = 1'b0;
          m_pc = {t[31:2], 2'b00};
        end else begin
          m_drain = 1'b1;
          m_tgt = {t[31:2], 2'b00};
        end
      end else if (m_skid) begin
        if (!s) begin
          m_skid = 1'b0;
          e_valid = 1'b1; e_pc = m_skid_pc; e_pc4 = m_skid_pc + 32'd4; e_instr = m_skid_ins;
        end
      end else if (m_drain) begin
        if (a) begin
          m_drain = 1'b0;
          m_pc = m_tgt;
        end
      end else if (a) begin
        if (s) begin
          m_skid = 1'b1; m_skid_pc = m_pc; m_skid_ins = d;
        end else begin
          e_valid = 1'b1; e_pc = m_pc; e_pc4 = m_pc + 32'd4; e_instr = d;
        end
        m_pc = m_pc + 32'd4;
      end
      tick();
    end
    imem_ack = 1'b0; stall = 1'b0; redirect = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    test_reset();
    test_zero_wait();
    test_latency3();
    test_stall_skid();
    test_redirect_drain();
    test_redirect_stall_ack();
    test_wrap_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
